// File: rtl/life_sequencer.sv
// Frame-synchronised sequencer for a Game-of-Life engine: collects step/seed/free-run
// requests, launches one engine operation at a time and commands the buffer swap.
module life_sequencer #(
  parameter int TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        run,
  input  logic        step,
  input  logic        seed,
  input  logic [3:0]  rate,
  output logic        eng_start,
  output logic        eng_seed,
  input  logic        eng_done,
  output logic        frame_swap,
  output logic        busy,
  output logic [15:0] gen_count,
  output logic        timeout_err,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START     = 2'd1;
  localparam logic [1:0] S_BUSY      = 2'd2;
  localparam logic [1:0] S_SWAP_WAIT = 2'd3;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          step_q, seed_q;
  logic          step_pend, seed_pend, run_pend;
  logic [3:0]    rate_cnt;
  logic          op_seed;
  logic [TW-1:0] to_cnt;
  logic [15:0]   gen_count_q;

  logic step_rise, seed_rise, run_hit;
  logic accept, sel_seed, sel_step, sel_run;

  always_comb begin
    step_rise = step & ~step_q;
    seed_rise = seed & ~seed_q;
    run_hit   = run & frame_tick & (rate_cnt == rate);
    accept    = (state == S_IDLE) & frame_tick & (seed_pend | step_pend | run_pend);
    // Fixed priority: a reseed beats a manual step, which beats the free-run timer.
    sel_seed  = accept & seed_pend;
    sel_step  = accept & ~seed_pend & step_pend;
    sel_run   = accept & ~seed_pend & ~step_pend & run_pend;
  end

  always_comb begin
    eng_start  = (state == S_START);
    eng_seed   = (state == S_START) & op_seed;
    frame_swap = (state == S_SWAP_WAIT) & frame_tick;
    busy       = (state != S_IDLE);
    gen_count  = gen_count_q;
    state_dbg  = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      step_q      <= step;
      seed_q      <= seed;
      step_pend   <= 1'b0;
      seed_pend   <= 1'b0;
      run_pend    <= 1'b0;
      rate_cnt    <= 4'd0;
      op_seed     <= 1'b0;
      to_cnt      <= '0;
      gen_count_q <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      step_q <= step;
      seed_q <= seed;

      // A new edge wins over the clear of the same flag so no request is lost.
      if (step_rise)     step_pend <= 1'b1;
      else if (sel_step) step_pend <= 1'b0;

      if (seed_rise)     seed_pend <= 1'b1;
      else if (sel_seed) seed_pend <= 1'b0;

      if (!run) begin
        rate_cnt <= 4'd0;
        run_pend <= 1'b0;
      end else begin
        if (frame_tick) begin
          if (rate_cnt == rate) rate_cnt <= 4'd0;
          else                  rate_cnt <= rate_cnt + 4'd1;
        end
        if (run_hit)      run_pend <= 1'b1;
        else if (sel_run) run_pend <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            state   <= S_START;
            op_seed <= seed_pend;
            to_cnt  <= '0;
          end
        end
        S_START: begin
          state  <= S_BUSY;
          to_cnt <= to_cnt + 1'b1;
        end
        S_BUSY: begin
          // The count includes the start cycle, so the engine gets TIMEOUT cycles in total.
          if (eng_done) begin
            state <= S_SWAP_WAIT;
          end else if (to_cnt == TO_LAST) begin
            state       <= S_IDLE;
            timeout_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_SWAP_WAIT: begin
          if (frame_tick) begin
            state       <= S_IDLE;
            gen_count_q <= op_seed ? 16'd0 : gen_count_q + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer: a per-cycle vector table plus hand-built
// sequences for timing, free-run, timeout, wrap and reset corner cases.
module tb_life_sequencer;

  logic        clk;
  logic        reset;
  logic        frame_tick, run, step, seed, eng_done;
  logic [3:0]  rate;
  logic        eng_start, eng_seed, frame_swap, busy, timeout_err;
  logic [15:0] gen_count;
  logic [1:0]  state_dbg;
  logic        eng_start_t, eng_seed_t, frame_swap_t, busy_t, timeout_err_t;
  logic [15:0] gen_count_t;
  logic [1:0]  state_dbg_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  life_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run), .step(step),
    .seed(seed), .rate(rate), .eng_start(eng_start), .eng_seed(eng_seed),
    .eng_done(eng_done), .frame_swap(frame_swap), .busy(busy),
    .gen_count(gen_count), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  life_sequencer #(.TIMEOUT(16)) dut_t (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run), .step(step),
    .seed(seed), .rate(rate), .eng_start(eng_start_t), .eng_seed(eng_seed_t),
    .eng_done(eng_done), .frame_swap(frame_swap_t), .busy(busy_t),
    .gen_count(gen_count_t), .timeout_err(timeout_err_t), .state_dbg(state_dbg_t)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic ft, st, sd, dn;
    logic start, eseed, swap, bsy;
    logic [15:0] gc;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(input logic ft, st, sd, dn, start, eseed, swap, bsy,
                              input logic [15:0] gc);
    vec_t v;
    v.ft = ft; v.st = st; v.sd = sd; v.dn = dn;
    v.start = start; v.eseed = eseed; v.swap = swap; v.bsy = bsy; v.gc = gc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; frame_tick = 1'b0; eng_done = 1'b0; run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One manual step generation; optionally lands eng_done on the same cycle as a frame_tick.
  task automatic gen_once(input logic coincide, input string tag);
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      step       = (c == 0);
      frame_tick = (c == 2) || (c == 8) || (coincide && c == 6);
      eng_done   = (c == 6);
      #1;
      if (c == 3) check({tag, "_start"}, {31'd0, eng_start}, 32'd1);
      if (c == 6) check({tag, "_no_swap_at_done"}, {31'd0, frame_swap}, 32'd0);
      if (c == 7) check({tag, "_swap_wait"}, {31'd0, busy}, 32'd1);
      if (c == 8) check({tag, "_swap"}, {31'd0, frame_swap}, 32'd1);
    end
    @(negedge clk);
    frame_tick = 1'b0; eng_done = 1'b0;
  endtask

  initial begin
    int start_cyc, swap_cyc, n_start, n_swap, start_seed;
    int done_at, last_tick, overlap, t_start, n_swap_t;
    logic b15, b16, chk_next;
    logic [15:0] start_mask, swap_mask;

    reset = 1'b1; frame_tick = 1'b0; run = 1'b0; step = 1'b0; seed = 1'b0;
    rate = 4'd0; eng_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {11'd0, eng_start, eng_seed, frame_swap, busy, timeout_err, gen_count},
          32'd0);
    check("reset_outputs_t", {11'd0, eng_start_t, eng_seed_t, frame_swap_t, busy_t, timeout_err_t,
          gen_count_t}, 32'd0);
    reset = 1'b0;

    // Vector table: ft st sd dn | start eseed swap busy gen_count
    vecs[0]  = mk(0,0,0,0, 0,0,0,0, 16'd0);
    vecs[1]  = mk(0,1,1,0, 0,0,0,0, 16'd0);
    vecs[2]  = mk(1,1,1,0, 0,0,0,0, 16'd0);
    vecs[3]  = mk(0,1,1,0, 1,1,0,1, 16'd0);
    vecs[4]  = mk(0,1,1,0, 0,0,0,1, 16'd0);
    vecs[5]  = mk(0,1,1,1, 0,0,0,1, 16'd0);
    vecs[6]  = mk(0,1,1,1, 0,0,0,1, 16'd0);
    vecs[7]  = mk(1,1,1,0, 0,0,1,1, 16'd0);
    vecs[8]  = mk(0,1,1,0, 0,0,0,0, 16'd0);
    vecs[9]  = mk(1,1,1,0, 0,0,0,0, 16'd0);
    vecs[10] = mk(0,1,1,0, 1,0,0,1, 16'd0);
    vecs[11] = mk(0,1,1,1, 0,0,0,1, 16'd0);
    vecs[12] = mk(1,1,1,0, 0,0,1,1, 16'd0);
    vecs[13] = mk(0,1,1,0, 0,0,0,0, 16'd1);
    vecs[14] = mk(1,0,0,0, 0,0,0,0, 16'd1);
    vecs[15] = mk(0,0,0,0, 0,0,0,0, 16'd1);
    vecs[16] = mk(0,1,0,0, 0,0,0,0, 16'd1);
    vecs[17] = mk(1,1,0,0, 0,0,0,0, 16'd1);
    vecs[18] = mk(0,0,0,0, 1,0,0,1, 16'd1);
    vecs[19] = mk(0,1,0,0, 0,0,0,1, 16'd1);
    vecs[20] = mk(0,1,0,1, 0,0,0,1, 16'd1);
    vecs[21] = mk(1,1,0,0, 0,0,1,1, 16'd1);
    vecs[22] = mk(0,1,0,0, 0,0,0,0, 16'd2);
    vecs[23] = mk(1,1,0,0, 0,0,0,0, 16'd2);
    vecs[24] = mk(0,1,0,0, 1,0,0,1, 16'd2);
    vecs[25] = mk(0,1,0,1, 0,0,0,1, 16'd2);
    vecs[26] = mk(0,1,0,0, 0,0,0,1, 16'd2);
    vecs[27] = mk(1,1,0,0, 0,0,1,1, 16'd2);
    vecs[28] = mk(0,1,0,0, 0,0,0,0, 16'd3);

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      frame_tick = vecs[i].ft; step = vecs[i].st; seed = vecs[i].sd; eng_done = vecs[i].dn;
      #1;
      check($sformatf("vec[%0d]", i),
            {12'd0, eng_start, eng_seed, frame_swap, busy, gen_count},
            {12'd0, vecs[i].start, vecs[i].eseed, vecs[i].swap, vecs[i].bsy, vecs[i].gc});
    end

    // Reset while BUSY with step held: abort, ignore late done, no phantom edge.
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      step       = !(c == 0 || c == 3 || c == 11);
      frame_tick = (c == 2) || (c == 9) || (c == 13);
      reset      = (c == 5) || (c == 6);
      eng_done   = (c == 7);
      #1;
      if (c == 4) check("pre_reset_busy", {31'd0, busy}, 32'd1);
      if (c == 6) check("reset_in_busy", {9'd0, eng_start, eng_seed, frame_swap, busy,
                        timeout_err, state_dbg, gen_count}, 32'd0);
      if (c == 8) check("late_done_ignored", {31'd0, busy}, 32'd0);
      if (c == 10) check("held_step_no_edge", {30'd0, busy, eng_start}, 32'd0);
      if (c == 14) check("repress_starts", {30'd0, eng_start, eng_seed}, 32'b10);
    end
    @(negedge clk);
    frame_tick = 1'b0; eng_done = 1'b0; step = 1'b0;

    // Step timing: tick at 100, done at 150, tick at 300.
    do_reset();
    n_start = 0; n_swap = 0; start_cyc = -1; swap_cyc = -1; start_seed = -1;
    for (int cyc = 0; cyc <= 320; cyc++) begin
      @(negedge clk);
      step       = (cyc == 5) || (cyc == 6);
      frame_tick = (cyc == 100) || (cyc == 300);
      eng_done   = (cyc == 150);
      #1;
      if (eng_start) begin n_start++; start_cyc = cyc; start_seed = int'(eng_seed); end
      if (frame_swap) begin n_swap++; swap_cyc = cyc; end
    end
    check("step_start_cycle", start_cyc, 32'd101);
    check("step_start_count", n_start, 32'd1);
    check("step_eng_seed", start_seed, 32'd0);
    check("step_swap_cycle", swap_cyc, 32'd300);
    check("step_swap_count", n_swap, 32'd1);
    check("step_gen_count", {16'd0, gen_count}, 32'd1);

    // Free run, rate=2: three warm-up ticks arm the timer, then 12 ticks are counted.
    do_reset();
    rate = 4'd2; run = 1'b1;
    done_at = -1; last_tick = 0; overlap = 0; chk_next = 1'b0;
    start_mask = 16'd0; swap_mask = 16'd0;
    exp_q = {16'd1, 16'd2, 16'd3, 16'd4};
    for (int cyc = 0; cyc <= 340; cyc++) begin
      @(negedge clk);
      frame_tick = (cyc % 20 == 10) && (cyc < 300);
      eng_done   = (cyc == done_at);
      if (frame_tick) last_tick = cyc / 20 + 1;
      #1;
      if (chk_next) begin
        chk_next = 1'b0;
        if (exp_q.size() == 0) check("run_sb_underflow", 32'd1, 32'd0);
        else check("run_sb_gen_count", {16'd0, gen_count}, {16'd0, exp_q.pop_front()});
      end
      if (eng_start) begin start_mask[last_tick] = 1'b1; done_at = cyc + 10; end
      if (frame_swap) begin swap_mask[last_tick] = 1'b1; chk_next = 1'b1; end
      if (eng_start && frame_swap) overlap++;
    end
    run = 1'b0;
    check("run_start_ticks", {16'd0, start_mask}, 32'h2490);
    check("run_swap_ticks", {16'd0, swap_mask}, 32'h4920);
    check("run_gen_count", {16'd0, gen_count}, 32'd4);
    check("run_no_overlap", overlap, 32'd0);
    check("run_sb_empty", exp_q.size(), 32'd0);

    // Timeout on the TIMEOUT=16 instance: engine never answers.
    do_reset();
    t_start = -1; n_swap_t = 0; b15 = 1'b0; b16 = 1'b1;
    for (int cyc = 0; cyc <= 80; cyc++) begin
      @(negedge clk);
      step       = (cyc == 2);
      frame_tick = (cyc == 10) || (cyc == 40) || (cyc == 60);
      eng_done   = 1'b0;
      #1;
      if (eng_start_t && t_start < 0) t_start = cyc;
      if (t_start >= 0 && cyc == t_start + 15) b15 = busy_t;
      if (t_start >= 0 && cyc == t_start + 16) b16 = busy_t;
      if (frame_swap_t) n_swap_t++;
    end
    check("to_start_cycle", t_start, 32'd11);
    check("to_busy_at_15", {31'd0, b15}, 32'd1);
    check("to_idle_at_16", {31'd0, b16}, 32'd0);
    check("to_err_set", {31'd0, timeout_err_t}, 32'd1);
    check("to_no_swap", n_swap_t, 32'd0);
    check("to_gen_count", {16'd0, gen_count_t}, 32'd0);
    check("to_default_no_err", {31'd0, timeout_err}, 32'd0);

    // Wrap: preload the counter near the top, then step twice.
    do_reset();
    @(negedge clk);
    force dut.gen_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.gen_count_q;
    #1;
    check("wrap_preload", {16'd0, gen_count}, 32'h0000FFFE);
    gen_once(1'b0, "wrap_a");
    check("wrap_ffff", {16'd0, gen_count}, 32'h0000FFFF);
    gen_once(1'b1, "wrap_b");
    check("wrap_zero", {16'd0, gen_count}, 32'h00000000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/life_sequencer.md
LIFE_SEQUENCER -- requirements
Module: life_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 1048576: max clk cycles allowed between eng_start and eng_done.
REQ-002 clk  input  1  system clock (100 MHz); all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 frame_tick  input  1  one-cycle pulse at start of vertical blanking.
REQ-005 run  input  1  level; 1 = free-running generations.
REQ-006 step  input  1  synchronized button level; rising edge requests one generation.
REQ-007 seed  input  1  synchronized button level; rising edge requests a reseed from LFSR.
REQ-008 rate  input  4  free-run period: one generation request every rate+1 frame_ticks.
REQ-009 eng_start  output  1  one-cycle start pulse to the life engine.
REQ-010 eng_seed  output  1  valid with eng_start; 1 = load LFSR pattern, 0 = compute next generation.
REQ-011 eng_done  input  1  one-cycle completion pulse from the life engine.
REQ-012 frame_swap  output  1  one-cycle pulse commanding display buffer swap.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 gen_count  output  16  generations displayed since last reseed.
REQ-015 timeout_err  output  1  sticky: engine failed to answer within TIMEOUT.

Function
REQ-016 States: IDLE, START, BUSY, SWAP_WAIT; encoding is implementation choice.
REQ-017 Edge detect: step/seed rising edge = input 1 while its registered previous value is 0; an edge sets step_pend / seed_pend respectively; edges accepted in every state.
REQ-018 Rate counter: 4-bit, increments on each frame_tick while run=1; on frame_tick with count==rate, clears to 0 and sets run_pend; run=0 holds counter at 0 and clears run_pend.
REQ-019 Pending flags saturate (repeat requests while pending are merged, not queued).
REQ-020 IDLE: on frame_tick with any pending flag set -> START; otherwise stay.
REQ-021 Priority at IDLE->START: seed_pend > step_pend > run_pend; only the selected flag clears; eng_seed latched = 1 iff seed selected.
REQ-022 START: eng_start=1 for exactly that cycle (one cycle after the accepting frame_tick), timeout counter cleared -> BUSY.
REQ-023 BUSY: eng_done -> SWAP_WAIT; timeout counter reaching TIMEOUT-1 without eng_done -> IDLE, set timeout_err, no swap, gen_count unchanged.
REQ-024 SWAP_WAIT: on next frame_tick (never the same cycle as eng_done) pulse frame_swap -> IDLE; at that cycle gen_count <= 0 if operation was seed, else gen_count+1 mod 2^16 (wraps 0xFFFF->0x0000).
REQ-025 frame_tick accepted to leave SWAP_WAIT does not also start a new generation; minimum spacing is one generation per two frames.
REQ-026 eng_done outside BUSY is ignored.
REQ-027 Changing rate mid-count takes effect at the next comparison; count > new rate waits for 4-bit wrap.
REQ-028 eng_start and frame_swap never both asserted in the same cycle.

Reset
REQ-029 reset while asserted forces: state IDLE, eng_start=0, eng_seed=0, frame_swap=0, busy=0, gen_count=0, timeout_err=0, all pending flags and rate counter 0, edge-detect registers loaded with current step/seed values (held button produces no edge after reset).
REQ-030 reset mid-operation (any state) aborts without frame_swap; a later eng_done from the aborted operation is ignored per REQ-026.

Verification
REQ-031 Step: run=0, pulse step, frame_tick at cycle 100, eng_done at 150, frame_tick at 300 -> eng_start at 101 with eng_seed=0, frame_swap at 300, gen_count=1.
REQ-032 Free run: run=1, rate=2, engine answers in 10 cycles, 12 frame_ticks -> generations every 3rd tick start, gen_count=4 after 12 ticks, no frame_tick both swaps and starts.
REQ-033 Priority: step and seed edges both pending at frame_tick -> eng_seed=1 first; next accepting tick runs step with eng_seed=0; gen_count 0 then 1.
REQ-034 Timeout: TIMEOUT=16, never assert eng_done -> return to IDLE 16 cycles after eng_start, timeout_err=1, frame_swap never pulses, gen_count unchanged.
REQ-035 Wrap/coincidence: preload gen_count 0xFFFF via step sequence; eng_done coincident with frame_tick -> swap at following frame_tick, gen_count=0x0000.
REQ-036 Reset in BUSY with step held high -> all outputs 0, late eng_done ignored, no new request until step released and pressed again.
